hazard_scoreboard: RTL and testbench
====================================

// Module: hazard_scoreboard
// PURPOSE
//  Parametrised forwarding/hazard unit for the 5-stage pipeline; successor to the fixed ALU-only forwarding logic.
//  Tracks every in-flight register write with a per-register countdown, supports variable result latency
//  (ALU=1, load=2, mult up to MAX_LAT), issues load-use/multi-cycle stalls, WAW stalls and registered forward selects.
//  Sits beside the ID/EX pipe register: consumes decoded ID fields, drives the EX operand muxes and PC/ID hold.
// PARAMETERS
//  NREG     32  number of architectural registers tracked (register 0 never tracked)
//  AW       5   register address width, AW = clog2(NREG)
//  MAX_LAT  4   largest producer latency in cycles (EX entry to forwardable result)
//  LW       3   width of latency/countdown fields, must hold MAX_LAT+1
// PORTS
//  clk          in   1       pipeline clock
//  rst          in   1       synchronous, active-high reset
//  id_valid     in   1       instruction present in ID
//  id_flush     in   1       branch/jump kill of the ID instruction this cycle
//  id_rs        in   AW      source A address
//  id_rt        in   AW      source B address
//  id_rs_used   in   1       source A is read
//  id_rt_used   in   1       source B is read
//  id_wr_en     in   1       instruction writes a register
//  id_wr_addr   in   AW      destination address
//  id_lat       in   LW      producer latency, 1..MAX_LAT
//  stall        out  1       hold PC and IF/ID, insert bubble into ID/EX (combinational)
//  issue        out  1       ID instruction advances to EX this cycle (combinational)
//  fwd_a        out  2       EX operand A select, registered, aligned with the EX-stage instruction
//  fwd_b        out  2       EX operand B select, registered
//  pending_cnt  out  AW+1    number of nonzero scoreboard entries, registered
// BEHAVIOUR
//  - Entry per register: cnt[r] (LW bits). 0 = value in register file.
//  - Consumer view in ID: cnt>=3 -> stall; cnt==2 -> FWD_MEM; cnt==1 -> FWD_WB; cnt==0 -> FWD_RF.
//  - An unused source (rs_used/rt_used=0) or an address of 0 never stalls and always selects FWD_RF.
//  - WAW: stall if id_wr_en && id_wr_addr!=0 && cnt[id_wr_addr] > id_lat+1, so results never complete out of order.
//  - stall = id_valid & ~id_flush & (RAW stall on A | RAW stall on B | WAW stall).
//  - issue = id_valid & ~id_flush & ~stall.
//  - Every clock edge, every nonzero cnt decrements by 1, saturating at 0.
//  - On an issue edge with id_wr_en and id_wr_addr!=0: cnt[id_wr_addr] <= id_lat+1.
//    This write overrides the decrement of that same entry.
//  - On an issue edge: fwd_a/fwd_b <= the selects computed in ID. On a non-issue edge (stall, flush, no valid):
//    fwd_a/fwd_b <= FWD_RF, i.e. a bubble.
//  - Forwarding is computed before the issue write, so an instruction reading its own destination sees the old entry.
//  - Latency 1 producer followed by a dependent instruction: no stall, FWD_MEM.
//    Latency 2 (load): exactly 1 stall cycle, then FWD_MEM.
//  - id_lat of 0 or >MAX_LAT: treated as MAX_LAT. A flush has no effect on entries already issued.
//  - rst: all cnt <= 0; fwd_a, fwd_b <= FWD_RF; pending_cnt <= 0.
//    stall and issue are forced to 0 while rst is high. Reset mid-stall drops the pending hazard.
//  - pending_cnt reflects the entries after the current edge's update.
// STRUCTURE
//  - Shared include hazard_defs.vh holds: FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10 (the existing 4:1 operand-mux
//    encoding, 2'b11 reserved), LAT_ALU=1, LAT_LOAD=2, LAT_MULT=MAX_LAT.
//  - Sub-module: scoreboard_entry (one per register; load/decrement/saturate counter, exposes cnt),
//    generated for r=1..NREG-1.
//  - Top level holds the two read-side decoders, the stall/issue logic, the fwd registers and a popcount.
// TESTING
//  1. rst high 2 cycles with random ID inputs -> stall=0, issue=0, fwd_a=fwd_b=00, pending_cnt=0.
//  2. ALU writes r5 (lat 1), next instr reads rs=r5 -> no stall; fwd_a=10 in EX.
//     An instr 2 later reading rt=r5 -> fwd_b=01; 3 later -> 00.
//  3. Load writes r8 (lat 2), next instr reads r8 -> stall=1 for exactly 1 cycle, fwd bubble 00, then fwd=10.
//  4. Mult writes r3 (lat 4), next instr reads r3 -> stall 3 cycles, then fwd=10; pending_cnt=1 while waiting.
//  5. Mult to r3, then ALU to r3 -> WAW stall until cnt[3]<=2.
//     Then a reader of r3 forwards from the ALU result, not the mult result.
//  6. Writes to r0 and reads of r0 -> never stall, pending_cnt stays 0.
//     id_flush during a would-stall cycle -> stall=0, issue=0, entries unchanged.

Source files
------------

// File: rtl/hazard_scoreboard_pkg.sv
// Shared constants, types and helpers for the hazard scoreboard.
// Holds the operand-mux encoding and the producer latency classes.
package hazard_scoreboard_pkg;

  localparam int NREG    = 32;
  localparam int AW      = 5;
  localparam int MAX_LAT = 4;
  localparam int LW      = 3;

  // Existing 4:1 operand-mux encoding; 2'b11 is reserved.
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam logic [LW-1:0] LAT_ALU  = LW'(1);
  localparam logic [LW-1:0] LAT_LOAD = LW'(2);
  localparam logic [LW-1:0] LAT_MULT = LW'(MAX_LAT);

  typedef struct packed {
    logic       stall;
    logic [1:0] sel;
  } rd_t;

  // Latency of 0 or beyond MAX_LAT falls back to the slowest unit.
  function automatic logic [LW-1:0] lat_norm(
    input logic [LW-1:0] l
  );
    if (l == '0 || l > LW'(MAX_LAT))
      return LW'(MAX_LAT);
    return l;
  endfunction

  function automatic rd_t rd_decode(
    input logic [LW-1:0] c,
    input logic          used,
    input logic [AW-1:0] a
  );
    rd_t d;
    d.stall = 1'b0;
    d.sel   = FWD_RF;
    if (used && a != '0) begin
      unique case (1'b1)
        (c >= LW'(3)): d.stall = 1'b1;
        (c == LW'(2)): d.sel   = FWD_MEM;
        (c == LW'(1)): d.sel   = FWD_WB;
        default: ;
      endcase
    end
    return d;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// ID-side request and hazard response bundle.
// master drives decoded ID fields; slave is the scoreboard.
interface hazard_scoreboard_if;
  import hazard_scoreboard_pkg::*;

  logic          id_valid;
  logic          id_flush;
  logic [AW-1:0] id_rs;
  logic [AW-1:0] id_rt;
  logic          id_rs_used;
  logic          id_rt_used;
  logic          id_wr_en;
  logic [AW-1:0] id_wr_addr;
  logic [LW-1:0] id_lat;
  logic          stall;
  logic          issue;
  logic [1:0]    fwd_a;
  logic [1:0]    fwd_b;
  logic [AW:0]   pending_cnt;

  modport master (
    output id_valid, id_flush,
    output id_rs, id_rt,
    output id_rs_used, id_rt_used,
    output id_wr_en, id_wr_addr, id_lat,
    input  stall, issue,
    input  fwd_a, fwd_b, pending_cnt
  );

  modport slave (
    input  id_valid, id_flush,
    input  id_rs, id_rt,
    input  id_rs_used, id_rt_used,
    input  id_wr_en, id_wr_addr, id_lat,
    output stall, issue,
    output fwd_a, fwd_b, pending_cnt
  );

endinterface

// File: rtl/hazard_scoreboard_entry.sv
// One register's in-flight countdown: load, decrement, saturate at 0.
// o_nxt is the value the entry takes at the coming edge.
module scoreboard_entry
  import hazard_scoreboard_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          i_load,
  input  logic [LW-1:0] i_val,
  output logic [LW-1:0] o_cnt,
  output logic [LW-1:0] o_nxt
);

  logic [LW-1:0] r_cnt;
  logic [LW-1:0] w_nxt;

  always_comb begin
    w_nxt = '0;
    if (rst)
      w_nxt = '0;
    else if (i_load)
      w_nxt = i_val;
    else if (r_cnt != '0)
      w_nxt = r_cnt - LW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst)
      r_cnt <= '0;
    else
      r_cnt <= w_nxt;
  end

  assign o_cnt = r_cnt;
  assign o_nxt = w_nxt;

endmodule

// File: rtl/hazard_scoreboard.sv
// Forwarding/hazard unit: per-register countdowns, RAW/WAW stalls,
// registered EX forward selects and an in-flight entry count.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
(
  input logic                clk,
  input logic                rst,
  hazard_scoreboard_if.slave bus
);

  logic [LW-1:0] w_cnt [NREG];
  logic [LW-1:0] w_nxt [NREG];
  logic [LW-1:0] w_latp1;
  rd_t           w_a;
  rd_t           w_b;
  logic          w_waw;
  logic          w_go;
  logic          w_stall;
  logic          w_issue;
  logic [AW:0]   w_pop;
  logic [1:0]    r_fwd_a;
  logic [1:0]    r_fwd_b;
  logic [AW:0]   r_pend;

  assign w_cnt[0] = '0;
  assign w_nxt[0] = '0;

  for (genvar r = 1; r < NREG; r++) begin : g_ent
    logic w_load;
    assign w_load = w_issue & bus.id_wr_en &
                    (bus.id_wr_addr == AW'(r));
    scoreboard_entry u_ent (
      .clk    (clk),
      .rst    (rst),
      .i_load (w_load),
      .i_val  (w_latp1),
      .o_cnt  (w_cnt[r]),
      .o_nxt  (w_nxt[r])
    );
  end

  // Decoders read the pre-update entries, so a self-dependent
  // instruction sees the older producer.
  assign w_a = rd_decode(w_cnt[bus.id_rs],
                         bus.id_rs_used, bus.id_rs);
  assign w_b = rd_decode(w_cnt[bus.id_rt],
                         bus.id_rt_used, bus.id_rt);

  assign w_latp1 = lat_norm(bus.id_lat) + LW'(1);
  assign w_waw   = bus.id_wr_en &&
                   (bus.id_wr_addr != '0) &&
                   (w_cnt[bus.id_wr_addr] > w_latp1);

  assign w_go    = ~rst & bus.id_valid & ~bus.id_flush;
  assign w_stall = w_go & (w_a.stall | w_b.stall | w_waw);
  assign w_issue = w_go & ~w_stall;

  always_comb begin
    w_pop = '0;
    for (int i = 1; i < NREG; i++)
      w_pop = w_pop + (AW+1)'(w_nxt[i] != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fwd_a <= FWD_RF;
      r_fwd_b <= FWD_RF;
      r_pend  <= '0;
    end else begin
      r_fwd_a <= w_issue ? w_a.sel : FWD_RF;
      r_fwd_b <= w_issue ? w_b.sel : FWD_RF;
      r_pend  <= w_pop;
    end
  end

  assign bus.stall       = w_stall;
  assign bus.issue       = w_issue;
  assign bus.fwd_a       = r_fwd_a;
  assign bus.fwd_b       = r_fwd_b;
  assign bus.pending_cnt = r_pend;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: ALU/load/mult forwarding,
// WAW ordering, r0, flush, latency fallback and reset mid-stall.
module tb_hazard_scoreboard;
  import hazard_scoreboard_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  hazard_scoreboard_if bus ();

  hazard_scoreboard dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [7:0] obs,
                     input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic fl,
                       input int rs, input logic rsu,
                       input int rt, input logic rtu,
                       input logic we, input int wa,
                       input int lat);
    bus.id_valid   = v;
    bus.id_flush   = fl;
    bus.id_rs      = AW'(rs);
    bus.id_rs_used = rsu;
    bus.id_rt      = AW'(rt);
    bus.id_rt_used = rtu;
    bus.id_wr_en   = we;
    bus.id_wr_addr = AW'(wa);
    bus.id_lat     = LW'(lat);
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  // writer: dest wa, latency lat, no reads
  task automatic wr(input int wa, input int lat);
    drive(1, 0, 0, 0, 0, 0, 1, wa, lat);
  endtask

  task automatic rd_a(input int rs);
    drive(1, 0, rs, 1, 0, 0, 0, 0, 1);
  endtask

  task automatic rd_b(input int rt);
    drive(1, 0, 0, 0, rt, 1, 0, 0, 1);
  endtask

  initial begin
    // 1: reset with random ID activity
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive(1, 0, $urandom_range(31), 1,
            $urandom_range(31), 1, 1,
            $urandom_range(31), $urandom_range(7));
      chk("rst_stall", 8'(bus.stall), 8'd0);
      chk("rst_issue", 8'(bus.issue), 8'd0);
      tick();
    end
    chk("rst_fwd_a", 8'(bus.fwd_a), 8'h0);
    chk("rst_fwd_b", 8'(bus.fwd_b), 8'h0);
    chk("rst_pend", 8'(bus.pending_cnt), 8'd0);
    rst = 1'b0;
    idle();
    tick();

    // 2: ALU r5 then readers at distance 1, 2, 3
    wr(5, 1);
    chk("alu_issue", 8'(bus.issue), 8'd1);
    tick();
    chk("alu_pend", 8'(bus.pending_cnt), 8'd1);
    rd_a(5);
    chk("alu_d1_stall", 8'(bus.stall), 8'd0);
    tick();
    chk("alu_d1_fwd_a", 8'(bus.fwd_a), 8'h2);
    rd_b(5);
    tick();
    chk("alu_d2_fwd_b", 8'(bus.fwd_b), 8'h1);
    chk("alu_d2_fwd_a", 8'(bus.fwd_a), 8'h0);
    rd_b(5);
    tick();
    chk("alu_d3_fwd_b", 8'(bus.fwd_b), 8'h0);
    chk("alu_d3_pend", 8'(bus.pending_cnt), 8'd0);

    // 3: load r8, one stall then MEM forward
    wr(8, 2);
    tick();
    rd_a(8);
    chk("ld_stall", 8'(bus.stall), 8'd1);
    chk("ld_issue", 8'(bus.issue), 8'd0);
    tick();
    chk("ld_bubble", 8'(bus.fwd_a), 8'h0);
    chk("ld_stall2", 8'(bus.stall), 8'd0);
    tick();
    chk("ld_fwd_a", 8'(bus.fwd_a), 8'h2);
    idle();
    tick();

    // 4: mult r3, three stalls then MEM forward
    wr(3, 4);
    tick();
    rd_a(3);
    for (int i = 0; i < 3; i++) begin
      chk("mul_stall", 8'(bus.stall), 8'd1);
      tick();
      chk("mul_pend", 8'(bus.pending_cnt), 8'd1);
      chk("mul_bubble", 8'(bus.fwd_a), 8'h0);
    end
    chk("mul_go", 8'(bus.stall), 8'd0);
    tick();
    chk("mul_fwd_a", 8'(bus.fwd_a), 8'h2);
    idle();
    tick();
    chk("mul_pend0", 8'(bus.pending_cnt), 8'd0);

    // 5: mult r3 then ALU r3 -> WAW wait, reader sees ALU
    wr(3, 4);
    tick();
    wr(3, 1);
    for (int i = 0; i < 3; i++) begin
      chk("waw_stall", 8'(bus.stall), 8'd1);
      tick();
    end
    chk("waw_issue", 8'(bus.issue), 8'd1);
    tick();
    rd_a(3);
    chk("waw_rd_stall", 8'(bus.stall), 8'd0);
    tick();
    chk("waw_rd_fwd", 8'(bus.fwd_a), 8'h2);
    idle();
    tick();
    tick();

    // 6: r0 never tracked
    drive(1, 0, 0, 1, 0, 1, 1, 0, 4);
    chk("r0_stall", 8'(bus.stall), 8'd0);
    chk("r0_issue", 8'(bus.issue), 8'd1);
    tick();
    chk("r0_pend", 8'(bus.pending_cnt), 8'd0);
    chk("r0_fwd_a", 8'(bus.fwd_a), 8'h0);

    // flush on a would-stall cycle leaves entries alone
    wr(8, 2);
    tick();
    drive(1, 1, 8, 1, 0, 0, 0, 0, 1);
    chk("fl_stall", 8'(bus.stall), 8'd0);
    chk("fl_issue", 8'(bus.issue), 8'd0);
    tick();
    chk("fl_pend", 8'(bus.pending_cnt), 8'd1);
    rd_a(8);
    chk("fl_after_stall", 8'(bus.stall), 8'd0);
    tick();
    chk("fl_after_fwd", 8'(bus.fwd_a), 8'h2);
    idle();
    tick();

    // out-of-range latency behaves as MAX_LAT
    wr(9, 7);
    tick();
    rd_b(9);
    for (int i = 0; i < 3; i++) begin
      chk("lat7_stall", 8'(bus.stall), 8'd1);
      tick();
    end
    chk("lat7_go", 8'(bus.stall), 8'd0);
    tick();
    chk("lat7_fwd_b", 8'(bus.fwd_b), 8'h2);
    idle();
    tick();

    // reset during a load-use stall drops the hazard
    wr(10, 2);
    tick();
    rd_a(10);
    chk("rs_pre_stall", 8'(bus.stall), 8'd1);
    rst = 1'b1;
    #1;
    chk("rs_stall_rst", 8'(bus.stall), 8'd0);
    tick();
    chk("rs_pend", 8'(bus.pending_cnt), 8'd0);
    rst = 1'b0;
    #1;
    chk("rs_post_stall", 8'(bus.stall), 8'd0);
    chk("rs_post_issue", 8'(bus.issue), 8'd1);
    tick();
    chk("rs_post_fwd", 8'(bus.fwd_a), 8'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
